// File: rtl/zap_wb_slave_mem.sv
// Wishbone slave backed by a single-port word memory with byte lanes, optional
// wait states ahead of the first beat, and registered-feedback incrementing bursts.
module zap_wb_slave_mem #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [2:0]  i_wb_cti,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_wb_dat
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [2:0]  CtiIncr = 3'b010;

  typedef enum logic [2:0] {StIdle, StWait, StXfer, StBurst, StDone} state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdat_q, wdat_d;
  logic [2:0]  cti_q, cti_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdat_q, rdat_d;

  logic [31:0] mem [DEPTH];

  logic          respond;
  logic          in_range;
  logic          mem_we;
  logic [3:0]    mem_sel;
  logic [31:0]   mem_wdat;
  logic [AW-1:0] mem_idx;

  logic unused_adr;
  assign unused_adr = ^i_wb_adr[1:0];

  assign in_range = (addr_q[29:AW] == '0);
  assign mem_idx  = addr_q[AW-1:0];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    wdat_d   = wdat_q;
    cti_d    = cti_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdat_d   = '0;
    respond  = 1'b0;
    mem_we   = 1'b0;
    mem_sel  = sel_q;
    mem_wdat = wdat_q;

    unique case (state_q)
      StIdle: begin
        if (i_wb_cyc && i_wb_stb) begin
          addr_d  = i_wb_adr[31:2];
          we_d    = i_wb_we;
          sel_d   = i_wb_sel;
          wdat_d  = i_wb_dat;
          cti_d   = i_wb_cti;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? StWait : StXfer;
        end
      end
      StWait: begin
        if (!i_wb_cyc) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = StXfer;
        end
      end
      StXfer: begin
        // The response for the latched request is registered on the edge leaving XFER.
        if (!i_wb_cyc) begin
          state_d = StIdle;
        end else begin
          respond = 1'b1;
          state_d = (cti_q == CtiIncr) ? StBurst : StDone;
        end
      end
      StBurst: begin
        if (!i_wb_cyc) begin
          state_d = StIdle;
        end else if (i_wb_stb) begin
          respond  = 1'b1;
          mem_sel  = i_wb_sel;
          mem_wdat = i_wb_dat;
          cti_d    = i_wb_cti;
          state_d  = (i_wb_cti == CtiIncr) ? StBurst : StDone;
        end
      end
      StDone: begin
        // Swallows the edge where a classic master still holds stb after seeing ack.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (respond) begin
      addr_d = addr_q + 30'd1;
      if (in_range) begin
        ack_d = 1'b1;
        if (we_q) mem_we = 1'b1;
        else      rdat_d = mem[mem_idx];
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      cti_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      cti_q   <= cti_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_sel[b]) mem[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
      end
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_err = err_q;
  assign o_wb_dat = rdat_q;

endmodule

// File: tb/tb_zap_wb_slave_mem.sv
// Bench for zap_wb_slave_mem: a zero-wait and a three-wait instance, table vectors,
// randomized classic traffic against a word-array model, and burst/abort/reset sequences.
module tb_zap_wb_slave_mem;

  logic        clk;
  logic        reset_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [2:0]  cti;
  bit          use3;

  logic        ack0, err0, ack3, err3;
  logic [31:0] dat0, dat3;
  logic        cyc0, cyc3, stb0, stb3;
  logic        ack_o, err_o;
  logic [31:0] dat_o;

  assign cyc0  = cyc & ~use3;
  assign stb0  = stb & ~use3;
  assign cyc3  = cyc & use3;
  assign stb3  = stb & use3;
  assign ack_o = use3 ? ack3 : ack0;
  assign err_o = use3 ? err3 : err0;
  assign dat_o = use3 ? dat3 : dat0;

  zap_wb_slave_mem #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .i_clk(clk), .i_reset_n(reset_n), .i_wb_cyc(cyc0), .i_wb_stb(stb0), .i_wb_we(we),
    .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_cti(cti),
    .o_wb_ack(ack0), .o_wb_err(err0), .o_wb_dat(dat0)
  );

  zap_wb_slave_mem #(.DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
    .i_clk(clk), .i_reset_n(reset_n), .i_wb_cyc(cyc3), .i_wb_stb(stb3), .i_wb_we(we),
    .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_cti(cti),
    .o_wb_ack(ack3), .o_wb_err(err3), .o_wb_dat(dat3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Classic single transfer, called at a negedge. Holds stb one edge past the ack to
  // confirm no second response, then releases the bus.
  task automatic classic(input bit w_en, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [1:0] st, output int lat,
                         output logic [31:0] rd, output logic [1:0] dbl);
    cyc = 1'b1; stb = 1'b1; we = w_en; adr = a; sel = s; wdat = d; cti = 3'b000;
    st = 2'b00; lat = -1; rd = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack_o || err_o) begin
        st = {ack_o, err_o}; lat = n - 1; rd = dat_o;
        break;
      end
    end
    @(negedge clk);
    dbl = {ack_o, err_o};
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  logic       seq_stb [8];
  logic [2:0] seq_cti [8];
  logic [1:0] obs_st  [8];
  logic [31:0] obs_dat [8];

  // Burst read on the zero-wait instance; obs_*[i] holds outputs after request edge i.
  task automatic run_seq(input logic [31:0] adr0, input int n);
    use3 = 1'b0; we = 1'b0; sel = 4'hF; wdat = '0; adr = adr0;
    for (int i = 0; i < n; i++) begin
      cyc = 1'b1; stb = seq_stb[i]; cti = seq_cti[i];
      @(negedge clk);
      obs_st[i] = {ack_o, err_o};
      obs_dat[i] = dat_o;
    end
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
  endtask

  typedef struct {
    bit          use3;
    bit          we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [1:0]  exp_st;
    bit          chk_dat;
    logic [31:0] exp_dat;
    int          exp_lat;
  } vec_t;

  vec_t        tab [12];
  logic [31:0] ref_mem [128];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [1:0]  st, dbl, resp;
    logic [31:0] rd, w, d, mask, exp_dat;
    logic [1:0]  exp_st;
    logic [1:0]  exp_seq [8];
    int          lat;
    bit          oor, wr;
    logic [3:0]  s;

    tab[0]  = '{0, 1, 32'h10,   4'hF, 32'hDEADBEEF, 2'b10, 0, 32'h0,        1};
    tab[1]  = '{0, 0, 32'h10,   4'hF, 32'h0,        2'b10, 1, 32'hDEADBEEF, 1};
    tab[2]  = '{0, 1, 32'h10,   4'h5, 32'h11223344, 2'b10, 0, 32'h0,        1};
    tab[3]  = '{0, 0, 32'h10,   4'hF, 32'h0,        2'b10, 1, 32'hDE22BE44, 1};
    tab[4]  = '{0, 0, 32'h1000, 4'hF, 32'h0,        2'b01, 1, 32'h0,        1};
    tab[5]  = '{0, 1, 32'h0,    4'hF, 32'h55AA55AA, 2'b10, 0, 32'h0,        1};
    tab[6]  = '{0, 1, 32'h1000, 4'hF, 32'h0,        2'b01, 1, 32'h0,        1};
    tab[7]  = '{0, 0, 32'h0,    4'hF, 32'h0,        2'b10, 1, 32'h55AA55AA, 1};
    tab[8]  = '{1, 1, 32'h20,   4'hF, 32'hCAFEF00D, 2'b10, 0, 32'h0,        4};
    tab[9]  = '{1, 0, 32'h23,   4'hF, 32'h0,        2'b10, 1, 32'hCAFEF00D, 4};
    tab[10] = '{0, 0, 32'h13,   4'hF, 32'h0,        2'b10, 1, 32'hDE22BE44, 1};
    tab[11] = '{1, 0, 32'h1000, 4'hF, 32'h0,        2'b01, 1, 32'h0,        4};

    reset_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    cti = '0; use3 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack0", 32'(ack0), 32'h0);
    check("rst_err0", 32'(err0), 32'h0);
    check("rst_dat0", dat0, 32'h0);
    check("rst_ack3", 32'(ack3), 32'h0);
    check("rst_dat3", dat3, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      use3 = tab[i].use3;
      classic(tab[i].we, tab[i].adr, tab[i].sel, tab[i].dat, st, lat, rd, dbl);
      check($sformatf("tab%0d_status", i), 32'(st), 32'(tab[i].exp_st));
      check($sformatf("tab%0d_latency", i), 32'(lat), 32'(tab[i].exp_lat));
      check($sformatf("tab%0d_done_quiet", i), 32'(dbl), 32'h0);
      if (tab[i].chk_dat) check($sformatf("tab%0d_data", i), rd, tab[i].exp_dat);
    end

    // Randomized classic traffic on the zero-wait instance.
    use3 = 1'b0;
    for (int i = 0; i < 128; i++) begin
      d = $urandom;
      classic(1'b1, 32'(i) << 2, 4'hF, d, st, lat, rd, dbl);
      ref_mem[i] = d;
      check($sformatf("init%0d_status", i), 32'(st), 32'h2);
    end
    for (int t = 0; t < 300; t++) begin
      oor = ($urandom_range(0, 7) == 0);
      w   = oor ? 32'(1024 + $urandom_range(0, 1 << 20)) : 32'($urandom_range(0, 127));
      wr  = 1'($urandom_range(0, 1));
      s   = 4'($urandom);
      d   = $urandom;
      classic(wr, {w[29:0], 2'($urandom_range(0, 3))}, s, d, st, lat, rd, dbl);
      exp_dat = '0;
      if (oor) begin
        exp_st = 2'b01;
      end else begin
        exp_st = 2'b10;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (wr) ref_mem[w] = (ref_mem[w] & ~mask) | (d & mask);
        else    exp_dat = ref_mem[w];
      end
      check($sformatf("rnd%0d_status", t), 32'(st), 32'(exp_st));
      check($sformatf("rnd%0d_latency", t), 32'(lat), 32'd1);
      check($sformatf("rnd%0d_done_quiet", t), 32'(dbl), 32'h0);
      if (oor || !wr) check($sformatf("rnd%0d_data", t), rd, exp_dat);
    end

    // Four-beat burst from 0x100 with a one-cycle master stall before beat 3.
    seq_stb = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    seq_cti = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b111, 3'b000, 3'b000};
    run_seq(32'h100, 7);
    exp_seq = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
    for (int k = 0; k < 7; k++) check($sformatf("burstA_status%0d", k), 32'(obs_st[k]),
                                      32'(exp_seq[k]));
    check("burstA_data1", obs_dat[1], ref_mem[64]);
    check("burstA_data2", obs_dat[2], ref_mem[65]);
    check("burstA_data4", obs_dat[4], ref_mem[66]);
    check("burstA_data5", obs_dat[5], ref_mem[67]);

    // Burst crossing the top of memory: last word acks, next word errors.
    seq_stb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    seq_cti = '{3'b010, 3'b010, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    run_seq(32'hFFC, 4);
    exp_seq = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int k = 0; k < 4; k++) check($sformatf("burstB_status%0d", k), 32'(obs_st[k]),
                                      32'(exp_seq[k]));
    check("burstB_err_data", obs_dat[2], 32'h0);

    // Burst whose word address wraps from 2^30-1 to 0.
    run_seq(32'hFFFF_FFFC, 4);
    exp_seq = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int k = 0; k < 4; k++) check($sformatf("burstC_status%0d", k), 32'(obs_st[k]),
                                      32'(exp_seq[k]));
    check("burstC_err_data", obs_dat[1], 32'h0);
    check("burstC_wrap_data", obs_dat[2], ref_mem[0]);

    // Drop cyc while the three-wait instance is still waiting: no response, no write.
    use3 = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; sel = 4'hF; wdat = 32'h12345678;
    cti = 3'b000;
    repeat (2) @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    resp = 2'b00;
    repeat (8) begin
      @(negedge clk);
      resp |= {ack_o, err_o};
    end
    check("abort_no_response", 32'(resp), 32'h0);
    classic(1'b0, 32'h20, 4'hF, 32'h0, st, lat, rd, dbl);
    check("abort_readback_status", 32'(st), 32'h2);
    check("abort_readback_latency", 32'(lat), 32'd4);
    check("abort_readback_data", rd, 32'hCAFEF00D);

    // Asynchronous reset in the middle of a burst.
    use3 = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h100; sel = 4'hF; cti = 3'b010;
    @(negedge clk);
    @(negedge clk);
    check("rstburst_beat1_ack", 32'(ack_o), 32'h1);
    @(negedge clk);
    check("rstburst_beat2_ack", 32'(ack_o), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("rstburst_async_ack", 32'(ack_o), 32'h0);
    check("rstburst_async_dat", dat_o, 32'h0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    @(negedge clk);
    check("rstburst_held_ack", 32'(ack_o), 32'h0);
    reset_n = 1'b1;
    classic(1'b0, 32'h100, 4'hF, 32'h0, st, lat, rd, dbl);
    check("rstburst_after_status", 32'(st), 32'h2);
    check("rstburst_after_latency", 32'(lat), 32'd1);
    check("rstburst_after_data", rd, ref_mem[64]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
